div_share_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares the single iterative reciprocal/divide unit between several requesters: the matrix processor's W inversion, the rasterizer's edge setup and the texture LOD path.
- Accepts one signed fixed-point divide request at a time and issues it to the divider.
- Waits for completion, then returns the quotient to the originating requester.
- Divide-by-zero is resolved locally without occupying the divider.

---
 rtl/div_share_arbiter.sv | 218 +++++++++++++++++++++
 tb/tb_div_share_arbiter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_share_arbiter.sv
// rtl/div_share_arbiter.sv - round-robin sharing of one iterative Q16.16 divider among NUM_REQ requesters
//
// Optional feature macro: DIV_SHARE_ARBITER_TIMEOUT_EN (WAIT watchdog of TIMEOUT_CYCLES cycles).
//
// Ports:
//   clk, rst_n                       clock, synchronous active-low reset
//   req_valid / req_ready            per-requester handshake; ready is one-hot or zero, IDLE only
//   req_num / req_den                flattened operands, requester i at [i*DATA_W +: DATA_W]
//   resp_valid                       one-cycle response pulse to the owning requester
//   resp_quot, resp_dz, resp_timeout shared response payload, qualified by resp_valid
//   div_start, div_num, div_den      issue interface to the shared divider
//   div_finished, div_quot           completion interface from the shared divider
module div_share_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_num,
    input  logic [NUM_REQ*DATA_W-1:0] req_den,
    output logic [NUM_REQ-1:0]        resp_valid,
    output logic [DATA_W-1:0]         resp_quot,
    output logic                      resp_dz,
    output logic                      resp_timeout,
    output logic                      div_start,
    output logic [DATA_W-1:0]         div_num,
    output logic [DATA_W-1:0]         div_den,
    input  logic                      div_finished,
    input  logic [DATA_W-1:0]         div_quot
);

    localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CAND_W = IDX_W + 1;

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : gBadParams
        $error("div_share_arbiter: unsupported parameter set");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } stateType;

    stateType          state;
    stateType          stateNext;

    logic [IDX_W-1:0]  rrPtr;
    logic [IDX_W-1:0]  grant;
    logic [IDX_W-1:0]  winIdx;
    logic              winFound;
    logic [CAND_W-1:0] cand;
    logic [DATA_W-1:0] winNum;
    logic [DATA_W-1:0] winDen;
    logic              winDenZero;

    logic [DATA_W-1:0] numQ;
    logic [DATA_W-1:0] denQ;
    logic [DATA_W-1:0] quotQ;
    logic              dzQ;
    logic              timeoutQ;
    logic              timeoutHit;

    // Round-robin search starting at rrPtr; cand is one bit wider so the
    // wrap can be done with a single conditional subtract.
    always_comb begin
        winFound = 1'b0;
        winIdx   = '0;
        cand     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rrPtr} + CAND_W'(k);
            if (cand >= CAND_W'(NUM_REQ)) begin
                cand = cand - CAND_W'(NUM_REQ);
            end
            if (!winFound && req_valid[cand[IDX_W-1:0]]) begin
                winFound = 1'b1;
                winIdx   = cand[IDX_W-1:0];
            end
        end
    end

    assign winNum     = req_num[int'(winIdx)*DATA_W +: DATA_W];
    assign winDen     = req_den[int'(winIdx)*DATA_W +: DATA_W];
    assign winDenZero = (winDen == '0);

`ifdef DIV_SHARE_ARBITER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] waitCnt;

    // Counter is zero on the first WAIT cycle, so expiry on count
    // TIMEOUT_CYCLES-1 places the response TIMEOUT_CYCLES cycles after entry.
    always_ff @(posedge clk) begin
        if (!rst_n || state != WAIT) begin
            waitCnt <= '0;
        end else begin
            waitCnt <= waitCnt + CNT_W'(1);
        end
    end

    // A completion in the expiry cycle takes precedence over the abort.
    assign timeoutHit = (state == WAIT) && !div_finished &&
                        (waitCnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            timeoutQ <= 1'b0;
        end else if (state == IDLE && winFound) begin
            timeoutQ <= 1'b0;
        end else if (timeoutHit) begin
            timeoutQ <= 1'b1;
        end
    end
`else
    assign timeoutHit = 1'b0;
    assign timeoutQ   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE: begin
                if (winFound) begin
                    stateNext = winDenZero ? RESP : START;
                end
            end
            START:   stateNext = WAIT;
            WAIT: begin
                if (div_finished || timeoutHit) begin
                    stateNext = RESP;
                end
            end
            RESP:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Combinational outputs are forced low while reset is held so that a
    // requester holding req_valid through reset never sees a ready.
    always_comb begin
        req_ready    = '0;
        resp_valid   = '0;
        div_start    = 1'b0;
        resp_dz      = 1'b0;
        resp_timeout = 1'b0;
        if (rst_n) begin
            case (state)
                IDLE: begin
                    if (winFound) begin
                        req_ready = NUM_REQ'(1) << winIdx;
                    end
                end
                START: div_start = 1'b1;
                RESP: begin
                    resp_valid   = NUM_REQ'(1) << grant;
                    resp_dz      = dzQ;
                    resp_timeout = timeoutQ;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rrPtr <= '0;
            grant <= '0;
            numQ  <= '0;
            denQ  <= '0;
            quotQ <= '0;
            dzQ   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (winFound) begin
                        grant <= winIdx;
                        numQ  <= winNum;
                        denQ  <= winDen;
                        dzQ   <= winDenZero;
                        // Divide-by-zero saturates toward the numerator's sign.
                        if (winDenZero) begin
                            quotQ <= winNum[DATA_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                                                      : {1'b0, {(DATA_W-1){1'b1}}};
                        end
                    end
                end
                WAIT: begin
                    if (div_finished) begin
                        quotQ <= div_quot;
                    end else if (timeoutHit) begin
                        quotQ <= '0;
                    end
                end
                RESP: begin
                    rrPtr <= (grant == IDX_W'(NUM_REQ - 1)) ? '0 : grant + IDX_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign resp_quot = quotQ;
    assign div_num   = numQ;
    assign div_den   = denQ;

endmodule

// File: tb/tb_div_share_arbiter.sv
// tb/tb_div_share_arbiter.sv - self-checking bench for div_share_arbiter
module tb_div_share_arbiter;

    localparam int NUM_REQ        = 4;
    localparam int DATA_W         = 32;
    localparam int TIMEOUT_CYCLES = 64;

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*DATA_W-1:0] req_num;
    logic [NUM_REQ*DATA_W-1:0] req_den;
    logic [NUM_REQ-1:0]        resp_valid;
    logic [DATA_W-1:0]         resp_quot;
    logic                      resp_dz;
    logic                      resp_timeout;
    logic                      div_start;
    logic [DATA_W-1:0]         div_num;
    logic [DATA_W-1:0]         div_den;
    logic                      div_finished;
    logic [DATA_W-1:0]         div_quot;

    div_share_arbiter #(
        .NUM_REQ       (NUM_REQ),
        .DATA_W        (DATA_W),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_num     (req_num),
        .req_den     (req_den),
        .resp_valid  (resp_valid),
        .resp_quot   (resp_quot),
        .resp_dz     (resp_dz),
        .resp_timeout(resp_timeout),
        .div_start   (div_start),
        .div_num     (div_num),
        .div_den     (div_den),
        .div_finished(div_finished),
        .div_quot    (div_quot)
    );

    always #5 clk = ~clk;

    int errCount   = 0;
    int checkCount = 0;

    // Reference model state: round-robin pointer and the last quotient
    // delivered, which resp_quot must keep showing between responses.
    int                rrModel  = 0;
    logic [DATA_W-1:0] lastQuot = '0;

    task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checkCount++;
        if (got !== exp) begin
            errCount++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] refDiv(input logic [DATA_W-1:0] n, input logic [DATA_W-1:0] d);
        longint a;
        longint b;
        a = longint'($signed(n)) * 65536;
        b = longint'($signed(d));
        return DATA_W'(a / b);
    endfunction

    function automatic int modelWinner();
        for (int k = 0; k < NUM_REQ; k++) begin
            int i;
            i = (rrModel + k) % NUM_REQ;
            if (req_valid[i]) return i;
        end
        return -1;
    endfunction

    task automatic setReq(input int i, input logic [DATA_W-1:0] n, input logic [DATA_W-1:0] d);
        req_valid[i]                = 1'b1;
        req_num[i*DATA_W +: DATA_W] = n;
        req_den[i*DATA_W +: DATA_W] = d;
    endtask

    task automatic refill(input int pct, input bit allowDrop, input bit allowDz);
        logic [DATA_W-1:0] n;
        logic [DATA_W-1:0] d;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_valid[i]) begin
                if (allowDrop && $urandom_range(0, 9) == 0) req_valid[i] = 1'b0;
            end else if ($urandom_range(0, 99) < pct) begin
                n = $urandom;
                if ($urandom_range(0, 7) == 0) n = '0;
                d = $urandom >> $urandom_range(0, 24);
                if (d == '0) d = 32'd1;
                if (allowDz && $urandom_range(0, 5) == 0) d = '0;
                setReq(i, n, d);
            end
        end
    endtask

    // One arbitration round, entered and left #1 after a rising edge in IDLE.
    task automatic serve(input int lat, input bit spur, input bit noFinish,
                         input int pct, input bit allowDrop, input bit allowDz, output int g);
        logic [DATA_W-1:0] n;
        logic [DATA_W-1:0] d;
        logic [DATA_W-1:0] q;
        int w;
        @(negedge clk);
        w = modelWinner();
        checkEq("quot_hold", resp_quot, lastQuot);
        checkEq("idle_resp", resp_valid, 0);
        if (w < 0) begin
            checkEq("ready_none", req_ready, 0);
            div_finished = spur;
            div_quot     = $urandom;
            @(posedge clk); #1;
            div_finished = 1'b0;
            @(negedge clk);
            checkEq("spur_idle_resp", resp_valid, 0);
            checkEq("spur_idle_start", div_start, 0);
            @(posedge clk); #1;
            g = -1;
            return;
        end
        checkEq("req_ready", req_ready, 64'(1) << w);
        g = w;
        n = req_num[w*DATA_W +: DATA_W];
        d = req_den[w*DATA_W +: DATA_W];
        @(posedge clk); #1;
        req_valid[g] = 1'b0;
        if (d == '0) begin
            q = n[DATA_W-1] ? 32'h8000_0000 : 32'h7FFF_FFFF;
            refill(pct, allowDrop, allowDz);
            @(negedge clk);
            checkEq("dz_valid", resp_valid, 64'(1) << g);
            checkEq("dz_quot", resp_quot, q);
            checkEq("dz_flag", resp_dz, 1);
            checkEq("dz_timeout", resp_timeout, 0);
            checkEq("dz_start", div_start, 0);
            checkEq("dz_ready", req_ready, 0);
        end else begin
            q = refDiv(n, d);
            div_finished = spur;
            div_quot     = ~q;
            @(negedge clk);
            checkEq("div_start", div_start, 1);
            checkEq("div_num", div_num, n);
            checkEq("div_den", div_den, d);
            checkEq("start_ready", req_ready, 0);
            checkEq("start_resp", resp_valid, 0);
            @(posedge clk); #1;
            div_finished = 1'b0;
            repeat (noFinish ? TIMEOUT_CYCLES : lat) begin
                @(negedge clk);
                checkEq("wait_resp", resp_valid, 0);
                checkEq("wait_start", div_start, 0);
                checkEq("wait_num", div_num, n);
                checkEq("wait_den", div_den, d);
                @(posedge clk); #1;
            end
            if (noFinish) begin
                q = '0;
            end else begin
                div_finished = 1'b1;
                div_quot     = q;
                @(posedge clk); #1;
                div_finished = 1'b0;
                div_quot     = $urandom;
            end
            refill(pct, allowDrop, allowDz);
            @(negedge clk);
            checkEq("resp_valid", resp_valid, 64'(1) << g);
            checkEq("resp_quot", resp_quot, q);
            checkEq("resp_dz", resp_dz, 0);
            checkEq("resp_timeout", resp_timeout, 64'(noFinish));
            checkEq("resp_ready", req_ready, 0);
        end
        lastQuot = q;
        rrModel  = (g + 1) % NUM_REQ;
        @(posedge clk); #1;
    endtask

    task automatic checkAllZero(input string tag);
        checkEq({tag, "_ready"}, req_ready, 0);
        checkEq({tag, "_resp"}, resp_valid, 0);
        checkEq({tag, "_quot"}, resp_quot, 0);
        checkEq({tag, "_dz"}, resp_dz, 0);
        checkEq({tag, "_to"}, resp_timeout, 0);
        checkEq({tag, "_start"}, div_start, 0);
        checkEq({tag, "_num"}, div_num, 0);
        checkEq({tag, "_den"}, div_den, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, expected finish within time budget");
        $fatal(1);
    end

    initial begin
        int g;
        rst_n        = 1'b0;
        req_valid    = '0;
        req_num      = '0;
        req_den      = '0;
        div_finished = 1'b0;
        div_quot     = '0;

        // All requesters valid from reset for the round-robin check.
        for (int i = 0; i < NUM_REQ; i++) setReq(i, $urandom, 32'h0001_0000 + 32'(i));
        @(posedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        checkAllZero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int k = 0; k < 5; k++) begin
            serve($urandom_range(0, 4), 1'b0, 1'b0, 100, 1'b0, 1'b0, g);
            checkEq("rr_order", 64'(g), 64'(k % NUM_REQ));
        end
        req_valid = '0;

        // Single request: 1.0 / 2.0 = 0.5, divider finishes 10 cycles after start.
        setReq(0, 32'h0001_0000, 32'h0002_0000);
        serve(9, 1'b0, 1'b0, 0, 1'b0, 1'b0, g);
        checkEq("single_grant", 64'(g), 0);
        checkEq("single_quot", resp_quot, 32'h0000_8000);

        // Divide-by-zero, negative then zero numerator.
        setReq(2, 32'hFFFF_0000, 32'h0);
        serve(0, 1'b0, 1'b0, 0, 1'b0, 1'b0, g);
        checkEq("dzneg_grant", 64'(g), 2);
        checkEq("dzneg_quot", resp_quot, 32'h8000_0000);
        setReq(2, 32'h0, 32'h0);
        serve(0, 1'b0, 1'b0, 0, 1'b0, 1'b0, g);
        checkEq("dzzero_quot", resp_quot, 32'h7FFF_FFFF);

        // Spurious completions in IDLE and in START.
        serve(0, 1'b1, 1'b0, 0, 1'b0, 1'b0, g);
        setReq(1, 32'h0003_0000, 32'h0001_8000);
        serve(3, 1'b1, 1'b0, 0, 1'b0, 1'b0, g);
        checkEq("spur_start_quot", resp_quot, 32'h0002_0000);

        // Reset during WAIT: move the pointer past 0 first.
        setReq(2, 32'h0004_0000, 32'h0002_0000);
        serve(2, 1'b0, 1'b0, 0, 1'b0, 1'b0, g);
        setReq(3, 32'h0005_0000, 32'h0001_0000);
        @(negedge clk);
        checkEq("rst_pre_ready", req_ready, 64'(1) << 3);
        @(posedge clk); #1;
        req_valid[3] = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n        = 1'b1;
        div_finished = 1'b1;
        div_quot     = 32'h1234_5678;
        @(negedge clk);
        checkAllZero("rstwait");
        @(posedge clk); #1;
        div_finished = 1'b0;
        @(negedge clk);
        checkEq("rstwait_after_resp", resp_valid, 0);
        checkEq("rstwait_after_start", div_start, 0);
        @(posedge clk); #1;
        rrModel  = 0;
        lastQuot = '0;
        setReq(3, 32'h0001_0000, 32'h0001_0000);
        setReq(0, 32'h0002_0000, 32'h0001_0000);
        serve(1, 1'b0, 1'b0, 0, 1'b0, 1'b0, g);
        checkEq("rst_next_grant", 64'(g), 0);
        serve(1, 1'b0, 1'b0, 0, 1'b0, 1'b0, g);
        checkEq("rst_second_grant", 64'(g), 3);

`ifdef DIV_SHARE_ARBITER_TIMEOUT_EN
        setReq(1, 32'h0007_0000, 32'h0002_0000);
        serve(0, 1'b0, 1'b1, 0, 1'b0, 1'b0, g);
        checkEq("to_quot", resp_quot, 0);
        setReq(1, 32'h0007_0000, 32'h0002_0000);
        serve(TIMEOUT_CYCLES - 1, 1'b0, 1'b0, 0, 1'b0, 1'b0, g);
        checkEq("to_edge_quot", resp_quot, 32'h0003_8000);
`endif

        // Randomized traffic against the model.
        for (int it = 0; it < 300; it++) begin
            serve($urandom_range(0, 12), $urandom_range(0, 3) == 0, 1'b0, 40, 1'b1, 1'b1, g);
            if (g < 0) refill(60, 1'b0, 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
